// File: rtl/chroma_mode_sched_if.sv
// Handshake and data bundle between the chroma mode scheduler and its environment.
//   start/ready          : operation request and idle indication
//   pred_en/comp_sel/row_idx : control to the 8x8 chroma predictor
//   vrow/hrow/dcrow      : predicted row for V/H/DC modes (pixel k at [8k+7:8k])
//   orig_row/orig_valid/orig_ready : original row stream with handshake
//   best_mode/best_cost/done : decision result and update pulse
interface chroma_mode_sched_if;
  localparam int unsigned ROW_W  = 64;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned COST_W = 15;

  logic              start;
  logic              ready;
  logic              pred_en;
  logic              comp_sel;
  logic [IDX_W-1:0]  row_idx;
  logic [ROW_W-1:0]  vrow;
  logic [ROW_W-1:0]  hrow;
  logic [ROW_W-1:0]  dcrow;
  logic [ROW_W-1:0]  orig_row;
  logic              orig_valid;
  logic              orig_ready;
  logic [MODE_W-1:0] best_mode;
  logic [COST_W-1:0] best_cost;
  logic              done;

  // Environment side
  modport master (
    output start, vrow, hrow, dcrow, orig_row, orig_valid,
    input  ready, pred_en, comp_sel, row_idx, orig_ready, best_mode, best_cost, done
  );

  // Scheduler side
  modport slave (
    input  start, vrow, hrow, dcrow, orig_row, orig_valid,
    output ready, pred_en, comp_sel, row_idx, orig_ready, best_mode, best_cost, done
  );
endinterface

// File: rtl/chroma_mode_sched.sv
// Chroma intra mode scheduler: sequences the predictor over Cb then Cr
// (8 rows each), accumulates DC/H/V SADs across both components and
// registers the cheapest mode (ties -> lowest mode number).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : chroma_mode_sched_if.slave (see interface for signal list)
module chroma_mode_sched #(
  parameter int unsigned PRED_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  chroma_mode_sched_if.slave  bus
);
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned NPIX   = 8;
  localparam int unsigned ROW_W  = PIX_W * NPIX;
  localparam int unsigned SAD_W  = 11;
  localparam int unsigned ACC_W  = 15;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((PRED_LAT > 1) ? (PRED_LAT - 2) : 0);
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRED, S_WAIT, S_ACC, S_DECIDE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic               comp_q, comp_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [ACC_W-1:0]   acc_dc_q, acc_dc_d;
  logic [ACC_W-1:0]   acc_h_q, acc_h_d;
  logic [ACC_W-1:0]   acc_v_q, acc_v_d;
  logic [MODE_W-1:0]  best_mode_q, best_mode_d;
  logic [ACC_W-1:0]   best_cost_q, best_cost_d;
  logic               ready_q, ready_d;
  logic               pred_en_q, pred_en_d;
  logic               orig_ready_q, orig_ready_d;
  logic               done_q, done_d;

  logic               accept_c;
  logic [SAD_W-1:0]   sad_dc_c, sad_h_c, sad_v_c;

  // Sum of absolute pixel differences over one 8-pixel row
  function automatic logic [SAD_W-1:0] row_sad(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [SAD_W-1:0] s;
    logic [PIX_W-1:0] pa, pb;
    s = '0;
    for (int k = 0; k < int'(NPIX); k++) begin
      pa = a[k*PIX_W +: PIX_W];
      pb = b[k*PIX_W +: PIX_W];
      s  = s + SAD_W'((pa > pb) ? (pa - pb) : (pb - pa));
    end
    return s;
  endfunction

  assign accept_c = (state_q == S_ACC) && bus.orig_valid;
  assign sad_dc_c = row_sad(bus.orig_row, bus.dcrow);
  assign sad_h_c  = row_sad(bus.orig_row, bus.hrow);
  assign sad_v_c  = row_sad(bus.orig_row, bus.vrow);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_PRED;
      S_PRED:   state_d = (PRED_LAT == 1) ? S_ACC : S_WAIT;
      S_WAIT:   if (wait_q == WAIT_LAST) state_d = S_ACC;
      S_ACC:    if (accept_c && (row_q == LAST_ROW)) state_d = comp_q ? S_DECIDE : S_PRED;
      S_DECIDE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; status outputs follow the next state
  always_comb begin
    row_d        = row_q;
    comp_d       = comp_q;
    wait_d       = wait_q;
    acc_dc_d     = acc_dc_q;
    acc_h_d      = acc_h_q;
    acc_v_d      = acc_v_q;
    best_mode_d  = best_mode_q;
    best_cost_d  = best_cost_q;
    ready_d      = (state_d == S_IDLE);
    pred_en_d    = (state_d == S_PRED);
    orig_ready_d = (state_d == S_ACC);
    done_d       = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_dc_d = '0;
          acc_h_d  = '0;
          acc_v_d  = '0;
          comp_d   = 1'b0;
          row_d    = '0;
        end
      end
      S_PRED: wait_d = '0;
      S_WAIT: wait_d = wait_q + CNT_W'(1);
      S_ACC: begin
        if (accept_c) begin
          acc_dc_d = acc_dc_q + ACC_W'(sad_dc_c);
          acc_h_d  = acc_h_q  + ACC_W'(sad_h_c);
          acc_v_d  = acc_v_q  + ACC_W'(sad_v_c);
          // Row index wraps naturally from 7 to 0 for the Cr pass
          row_d    = row_q + IDX_W'(1);
          if ((row_q == LAST_ROW) && !comp_q) comp_d = 1'b1;
        end
      end
      S_DECIDE: begin
        // Non-strict compares keep the lower mode number on ties
        if ((acc_dc_q <= acc_h_q) && (acc_dc_q <= acc_v_q)) begin
          best_mode_d = MODE_W'(0);
          best_cost_d = acc_dc_q;
        end else if (acc_h_q <= acc_v_q) begin
          best_mode_d = MODE_W'(1);
          best_cost_d = acc_h_q;
        end else begin
          best_mode_d = MODE_W'(2);
          best_cost_d = acc_v_q;
        end
      end
      S_DONE: begin
        comp_d = 1'b0;
        row_d  = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q        <= '0;
      comp_q       <= 1'b0;
      wait_q       <= '0;
      acc_dc_q     <= '0;
      acc_h_q      <= '0;
      acc_v_q      <= '0;
      best_mode_q  <= '0;
      best_cost_q  <= '0;
      ready_q      <= 1'b1;
      pred_en_q    <= 1'b0;
      orig_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      row_q        <= row_d;
      comp_q       <= comp_d;
      wait_q       <= wait_d;
      acc_dc_q     <= acc_dc_d;
      acc_h_q      <= acc_h_d;
      acc_v_q      <= acc_v_d;
      best_mode_q  <= best_mode_d;
      best_cost_q  <= best_cost_d;
      ready_q      <= ready_d;
      pred_en_q    <= pred_en_d;
      orig_ready_q <= orig_ready_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.pred_en    = pred_en_q;
  assign bus.comp_sel   = comp_q;
  assign bus.row_idx    = row_q;
  assign bus.orig_ready = orig_ready_q;
  assign bus.best_mode  = best_mode_q;
  assign bus.best_cost  = best_cost_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_chroma_mode_sched.sv
// Directed bench for chroma_mode_sched: one PRED_LAT=1 instance and one
// PRED_LAT=3 instance sharing the predicted/original row stimulus.
module tb_chroma_mode_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3, ov;
  logic [63:0] vr, hr, dr, orr;
  int          vec = 0;
  int          err = 0;
  int          lat, pe, cs;
  bit          tog;
  bit          found;

  always #5 clk = ~clk;

  chroma_mode_sched_if b1();
  chroma_mode_sched_if b3();

  assign b1.start = start1;   assign b3.start = start3;
  assign b1.vrow = vr;        assign b3.vrow = vr;
  assign b1.hrow = hr;        assign b3.hrow = hr;
  assign b1.dcrow = dr;       assign b3.dcrow = dr;
  assign b1.orig_row = orr;   assign b3.orig_row = orr;
  assign b1.orig_valid = ov;  assign b3.orig_valid = ov;

  chroma_mode_sched #(.PRED_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  chroma_mode_sched #(.PRED_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one start and run to done; lat counts from the start cycle (cycle 0).
  task automatic run(input bit use3, input bit stall, input bit poke, input bit rel,
                     output int lat_o, output int pe_o, output int cs_o);
    int n;
    lat_o = -1; pe_o = 0; cs_o = 0; tog = 1'b0;
    @(negedge clk);
    if (rel) reset = 1'b1;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    ov = !stall;
    @(posedge clk);
    #1 start1 = 1'b0; start3 = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (use3 ? b3.pred_en : b1.pred_en) begin
        pe_o++;
        cs_o = cs_o | ((use3 ? b3.comp_sel : b1.comp_sel) ? 2 : 1);
      end
      if (use3 ? b3.done : b1.done) begin
        lat_o = n;
        break;
      end
      if (stall && (use3 ? b3.orig_ready : b1.orig_ready)) begin
        ov  = tog;
        tog = ~tog;
      end
      start3 = poke && (n == 5);
      @(posedge clk);
      n++;
    end
    start3 = 1'b0;
    ov = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},      32'(b1.ready), 1);
    check({tag, "_pred_en"},    32'(b1.pred_en), 0);
    check({tag, "_orig_ready"}, 32'(b1.orig_ready), 0);
    check({tag, "_done"},       32'(b1.done), 0);
    check({tag, "_comp_sel"},   32'(b1.comp_sel), 0);
    check({tag, "_row_idx"},    32'(b1.row_idx), 0);
    check({tag, "_best_mode"},  32'(b1.best_mode), 0);
    check({tag, "_best_cost"},  32'(b1.best_cost), 0);
  endtask

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0; ov = 1'b1;
    orr = {8{8'h80}}; vr = orr; hr = orr; dr = orr;
    repeat (2) @(negedge clk);
    check_reset_state("rst");

    // Flat block, start on the first edge after reset release
    run(0, 0, 0, 1, lat, pe, cs);
    check("flat_lat", 32'(lat), 20);
    check("flat_mode", 32'(b1.best_mode), 0);
    check("flat_cost", 32'(b1.best_cost), 0);
    check("flat_pe_cnt", 32'(pe), 2);
    check("flat_pe_comp", 32'(cs), 3);
    @(negedge clk);
    check("flat_done_pulse", 32'(b1.done), 0);
    check("flat_ready", 32'(b1.ready), 1);
    check("flat_idle_row", 32'(b1.row_idx), 0);
    check("flat_idle_comp", 32'(b1.comp_sel), 0);

    // Vertical exact match: V=0, H=128, DC=256
    orr = 64'h1716151413121110;
    vr = orr; hr = orr + {8{8'h01}}; dr = orr + {8{8'h02}};
    run(0, 0, 0, 0, lat, pe, cs);
    check("vert_mode", 32'(b1.best_mode), 2);
    check("vert_cost", 32'(b1.best_cost), 0);

    // V=128, DC=256, H=384
    vr = orr + {8{8'h01}}; hr = orr + {8{8'h03}}; dr = orr + {8{8'h02}};
    run(0, 0, 0, 0, lat, pe, cs);
    check("v128_mode", 32'(b1.best_mode), 2);
    check("v128_cost", 32'(b1.best_cost), 128);

    // H/V tie at 128, DC=256 -> H
    vr = orr + {8{8'h01}}; hr = vr; dr = orr + {8{8'h02}};
    run(0, 0, 0, 0, lat, pe, cs);
    check("hv_tie_mode", 32'(b1.best_mode), 1);
    check("hv_tie_cost", 32'(b1.best_cost), 128);

    // DC/H tie at 128, V=256 -> DC
    dr = orr + {8{8'h01}}; hr = dr; vr = orr + {8{8'h02}};
    run(0, 0, 0, 0, lat, pe, cs);
    check("dch_tie_mode", 32'(b1.best_mode), 0);
    check("dch_tie_cost", 32'(b1.best_cost), 128);

    // Result holds while idle with changing inputs
    vr = '0; hr = '0; dr = '0;
    repeat (4) @(negedge clk);
    check("hold_mode", 32'(b1.best_mode), 0);
    check("hold_cost", 32'(b1.best_cost), 128);

    // Flat block with a stall before every row: 16 extra cycles
    orr = {8{8'h80}}; vr = orr; hr = orr; dr = orr;
    run(0, 1, 0, 0, lat, pe, cs);
    check("stall_lat", 32'(lat), 36);
    check("stall_mode", 32'(b1.best_mode), 0);
    check("stall_cost", 32'(b1.best_cost), 0);

    // Extreme: 16 rows x 8 px x 255 = 32640 for every mode
    orr = {8{8'hFF}}; vr = '0; hr = '0; dr = '0;
    run(0, 0, 0, 0, lat, pe, cs);
    check("ext_lat", 32'(lat), 20);
    check("ext_mode", 32'(b1.best_mode), 0);
    check("ext_cost", 32'(b1.best_cost), 32640);

    // Reset during Cr row 3 aborts and clears the prior result
    @(negedge clk);
    start1 = 1'b1; ov = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b1.comp_sel && (b1.row_idx == 3'd3) && b1.orig_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_cr_row3", 32'(found), 1);
    reset = 1'b0;
    #1 check_reset_state("abort");
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(b1.done), 0);
    run(0, 0, 0, 1, lat, pe, cs);
    check("rerun_lat", 32'(lat), 20);
    check("rerun_mode", 32'(b1.best_mode), 0);
    check("rerun_cost", 32'(b1.best_cost), 32640);

    // PRED_LAT=3 instance with a start pulse while busy
    orr = {8{8'h80}}; vr = orr; hr = orr; dr = orr;
    run(1, 0, 1, 0, lat, pe, cs);
    check("lat3_lat", 32'(lat), 24);
    check("lat3_pe_cnt", 32'(pe), 2);
    check("lat3_pe_comp", 32'(cs), 3);
    check("lat3_mode", 32'(b3.best_mode), 0);
    check("lat3_cost", 32'(b3.best_cost), 0);
    repeat (3) @(negedge clk);
    check("lat3_no_restart", 32'(b3.ready), 1);
    check("lat3_no_pred_en", 32'(b3.pred_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/chroma_mode_sched.md
CHROMA_MODE_SCHED -- requirements
Module: chroma_mode_sched

Interface
REQ-001 SHALL have parameter PRED_LAT, default 1: clock cycles from a pred_en cycle until predictor outputs are valid, range 1..4.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-003 SHALL have clk: input, 1 bit, rising-edge clock for all state.
REQ-004 SHALL have reset: input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have start: input, 1 bit, requests mode decision for one 8x8 chroma macroblock pair (Cb, then Cr).
REQ-006 SHALL have ready: output, 1 bit, high only in IDLE.
REQ-007 SHALL have pred_en: output, 1 bit, enable to the 8x8 chroma predictor.
REQ-008 SHALL have comp_sel: output, 1 bit, neighbour source select, 0=Cb, 1=Cr.
REQ-009 SHALL have row_idx: output, 3 bits, prediction row currently being compared.
REQ-010 SHALL have vrow, hrow, dcrow: inputs, 64 bits each, 8 predicted pixels of row row_idx; pixel k is at bits [8k+7:8k].
REQ-011 SHALL have orig_row: input, 64 bits, 8 original pixels of the current row, same packing as REQ-010.
REQ-012 SHALL have orig_valid/orig_ready: input/output, 1 bit each, handshake for orig_row.
REQ-013 SHALL have best_mode: output, 2 bits, chosen mode: 0=DC, 1=horizontal, 2=vertical.
REQ-014 SHALL have best_cost: output, 15 bits, combined Cb+Cr SAD of best_mode.
REQ-015 SHALL have done: output, 1 bit, one-cycle pulse when best_mode/best_cost are updated.

Function
REQ-016 SHALL implement states IDLE, PRED, WAIT, ACC, DECIDE, DONE.
REQ-017 IDLE: on start=1, SHALL clear the three SAD accumulators, set comp_sel=0, and go to PRED; start outside IDLE SHALL be ignored.
REQ-018 PRED: SHALL drive pred_en=1 for exactly one cycle, then go to WAIT, or straight to ACC when PRED_LAT=1.
REQ-019 WAIT: SHALL remain for PRED_LAT-1 cycles, counted by an internal counter, then go to ACC.
REQ-020 ACC: SHALL drive orig_ready=1; orig_ready SHALL be 0 in every other state.
REQ-021 ACC: each cycle with orig_valid=1 SHALL add the 8-pixel SAD |orig-pred| (11 bits per row) of each mode to that mode's 15-bit accumulator, then increment row_idx.
REQ-022 ACC: cycles with orig_valid=0 SHALL leave accumulators and row_idx unchanged (stall of any length).
REQ-023 On acceptance of row 7: with comp_sel=0, SHALL set comp_sel=1, wrap row_idx to 0, and go to PRED; with comp_sel=1, SHALL go to DECIDE.
REQ-024 Accumulators SHALL NOT be cleared between Cb and Cr; costs are summed across components; maximum value is 32640, with no overflow.
REQ-025 DECIDE: SHALL register the mode with minimum cost into best_mode/best_cost; ties SHALL resolve to the lowest mode number (DC < H < V).
REQ-026 DONE: SHALL assert done=1 for one cycle, then go to IDLE.
REQ-027 best_mode/best_cost SHALL hold until the next DECIDE.
REQ-028 Unstalled latency SHALL be: start accepted at cycle 0 → done at cycle 18+2·PRED_LAT (cycle 20 for PRED_LAT=1).
REQ-029 row_idx and comp_sel SHALL change only as specified above; in IDLE they SHALL be 0.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE; ready=1; pred_en, orig_ready, done, comp_sel, row_idx=0; best_mode=0; best_cost=0; accumulators=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse; the prior best_mode/best_cost SHALL be lost (zeroed).
REQ-032 The first start after reset release SHALL be accepted in the first clk edge with reset=1.

Verification
REQ-033 Flat block: all pred rows and orig = 0x80, orig_valid always 1 → done at cycle 20, best_mode=0, best_cost=0 (tie, DC wins).
REQ-034 Vertical match: vrow=orig, hrow=orig+1 per pixel, dcrow=orig+2, both components → best_mode=2, best_cost=0; H cost 128 internally.
REQ-035 Stalls: REQ-033 stimulus with orig_valid low on every other cycle → same result; done delayed by exactly the number of stall cycles.
REQ-036 Extreme: orig=0xFF, all preds 0x00 → best_mode=0, best_cost=32640, no wrap.
REQ-037 Reset in ACC at Cr row 3 → outputs per REQ-030 immediately, no done; a new start completes normally.
REQ-038 PRED_LAT=3 with REQ-033 stimulus → done at cycle 24; pred_en high exactly 2 cycles total, one per comp_sel value; start pulsed while busy is ignored.
